// File: rtl/icap_warmboot_ctrl.sv
// ICAPE3 warm-boot sequencer: issues an optional WBSTAR write followed by IPROG,
// triggered by a valid/ready request or a synchronised edge on the reboot pin.
module icap_warmboot_ctrl #(
  parameter int          SYNC_STAGES    = 3,
  parameter int          AVAIL_TIMEOUT  = 1024,
  parameter int          BIT_SWAP       = 1,
  parameter int          REBOOT_WBSTAR  = 0,
  parameter logic [31:0] WBSTAR_DEFAULT = 32'h0
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        reboot,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wbstar,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  input  logic        icap_avail,
  output logic        icap_csib,
  output logic        icap_rdwrb,
  output logic [31:0] icap_i
);

  localparam int CNT_W = (AVAIL_TIMEOUT > 1) ? $clog2(AVAIL_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(AVAIL_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SEND
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_prev_q, sync_prev_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [3:0]             idx_q, idx_d;
  logic [31:0]            addr_q, addr_d;
  logic                   wbstar_q, wbstar_d;
  logic                   csib_q, csib_d;
  logic [31:0]            word_q, word_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [1:0]             err_q, err_d;
  logic                   ready_q, ready_d;

  logic        reboot_rise;
  logic [3:0]  seq_len;
  logic [31:0] cur_word;

  function automatic logic [31:0] swap_bits(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        r[8*b+i] = w[8*b+7-i];
      end
    end
    return r;
  endfunction

  assign reboot_rise = sync_q[SYNC_STAGES-1] & ~sync_prev_q;
  assign seq_len     = wbstar_q ? 4'd8 : 4'd6;

  // Command list; the WBSTAR pair is spliced in after the first type-1 NOOP.
  always_comb begin
    cur_word = 32'hFFFF_FFFF;
    if (wbstar_q) begin
      case (idx_q)
        4'd0:    cur_word = 32'hFFFF_FFFF;
        4'd1:    cur_word = 32'hAA99_5566;
        4'd2:    cur_word = 32'h2000_0000;
        4'd3:    cur_word = 32'h3002_0001;
        4'd4:    cur_word = addr_q;
        4'd5:    cur_word = 32'h3000_8001;
        4'd6:    cur_word = 32'h0000_000F;
        4'd7:    cur_word = 32'h2000_0000;
        default: cur_word = 32'hFFFF_FFFF;
      endcase
    end else begin
      case (idx_q)
        4'd0:    cur_word = 32'hFFFF_FFFF;
        4'd1:    cur_word = 32'hAA99_5566;
        4'd2:    cur_word = 32'h2000_0000;
        4'd3:    cur_word = 32'h3000_8001;
        4'd4:    cur_word = 32'h0000_000F;
        4'd5:    cur_word = 32'h2000_0000;
        default: cur_word = 32'hFFFF_FFFF;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[SYNC_STAGES-2:0], reboot};
    sync_prev_d = sync_q[SYNC_STAGES-1];
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    wbstar_d    = wbstar_q;
    csib_d      = 1'b1;
    word_d      = 32'hFFFF_FFFF;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        // A request beats a coincident reboot edge; the edge is simply lost.
        if (req_valid && ready_q) begin
          addr_d   = req_addr;
          wbstar_d = req_wbstar;
        end else if (reboot_rise) begin
          addr_d   = WBSTAR_DEFAULT;
          wbstar_d = (REBOOT_WBSTAR != 0);
        end
        if ((req_valid && ready_q) || reboot_rise) begin
          state_d = S_WAIT;
          busy_d  = 1'b1;
          err_d   = 2'b00;
          cnt_d   = '0;
          idx_d   = 4'd0;
        end
      end
      S_WAIT: begin
        if (icap_avail) begin
          state_d = S_SEND;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          err_d   = 2'b01;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SEND: begin
        if (idx_q == seq_len) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (!icap_avail) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          err_d   = 2'b10;
        end else begin
          csib_d = 1'b0;
          word_d = cur_word;
          idx_d  = idx_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ready_d = (state_d == S_IDLE);

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
      cnt_q       <= '0;
      idx_q       <= 4'd0;
      addr_q      <= 32'h0;
      wbstar_q    <= 1'b0;
      csib_q      <= 1'b1;
      word_q      <= 32'hFFFF_FFFF;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 2'b00;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      sync_prev_q <= sync_prev_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      wbstar_q    <= wbstar_d;
      csib_q      <= csib_d;
      word_q      <= word_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
    end
  end

  assign req_ready  = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign icap_csib  = csib_q;
  assign icap_rdwrb = 1'b0;
  assign icap_i     = (BIT_SWAP != 0) ? swap_bits(word_q) : word_q;

endmodule

// File: tb/tb_icap_warmboot_ctrl.sv
// Randomised bench for icap_warmboot_ctrl; expected behaviour is derived per
// transaction from the trigger cycle, avail pattern and the documented word list.
module tb_icap_warmboot_ctrl;

  localparam int          SYNC      = 3;
  localparam int          TMO       = 16;
  localparam int          REBOOT_WB = 0;
  localparam logic [31:0] WB_DEF    = 32'h0123_4000;

  logic        sys_clk;
  logic        rst_n;
  logic        reboot;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wbstar;
  logic        busy;
  logic        done;
  logic [1:0]  err;
  logic        icap_avail;
  logic        icap_csib;
  logic        icap_rdwrb;
  logic [31:0] icap_i;

  int          tests_run;
  int          tests_failed;
  logic [1:0]  last_err;

  icap_warmboot_ctrl #(
    .SYNC_STAGES   (SYNC),
    .AVAIL_TIMEOUT (TMO),
    .BIT_SWAP      (1),
    .REBOOT_WBSTAR (REBOOT_WB),
    .WBSTAR_DEFAULT(WB_DEF)
  ) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .reboot    (reboot),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wbstar(req_wbstar),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .icap_avail(icap_avail),
    .icap_csib (icap_csib),
    .icap_rdwrb(icap_rdwrb),
    .icap_i    (icap_i)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] unswap(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        r[8*b+i] = w[8*b+7-i];
      end
    end
    return r;
  endfunction

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic checkIdle(input logic [1:0] err_exp);
    checkOutput("idle_csib", {31'b0, icap_csib}, 32'd1);
    checkOutput("idle_icap_i", icap_i, 32'hFFFF_FFFF);
    checkOutput("idle_busy", {31'b0, busy}, 32'd0);
    checkOutput("idle_done", {31'b0, done}, 32'd0);
    checkOutput("idle_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("idle_err", {30'b0, err}, {30'b0, err_exp});
  endtask

  // w: cycles of avail=0 after the trigger; drop_d: word index whose cycle sees avail=0 (-1 none)
  task automatic applyStimulus(input bit use_req, input bit use_reboot, input logic [31:0] addr,
                               input bit wb, input int w, input int drop_d, input bit toggle_busy);
    logic [31:0] eff_addr;
    bit          eff_wb;
    logic [31:0] words[$];
    int          n, end_k, s, pin_e;
    bit          exp_csib, exp_busy, exp_done, exp_ready;
    logic [1:0]  exp_err;

    eff_addr = use_req ? addr : WB_DEF;
    eff_wb   = use_req ? wb : (REBOOT_WB != 0);
    words    = {32'hFFFF_FFFF, 32'hAA99_5566, 32'h2000_0000};
    if (eff_wb) begin
      words.push_back(32'h3002_0001);
      words.push_back(eff_addr);
    end
    words.push_back(32'h3000_8001);
    words.push_back(32'h0000_000F);
    words.push_back(32'h2000_0000);
    n       = words.size();
    pin_e   = 0;
    exp_err = 2'b00;

    if (use_reboot) begin
      for (int j = 0; j < SYNC; j++) begin
        reboot = 1'b1;
        step();
        pin_e++;
        checkOutput("sync_csib", {31'b0, icap_csib}, 32'd1);
        checkOutput("sync_busy", {31'b0, busy}, 32'd0);
      end
    end

    req_valid  = use_req;
    req_addr   = addr;
    req_wbstar = wb;
    icap_avail = 1'b0;
    reboot     = use_reboot && (pin_e < 5);
    step();
    pin_e++;
    req_valid = 1'b0;
    req_addr  = $urandom;
    checkOutput("accept_busy", {31'b0, busy}, 32'd1);
    checkOutput("accept_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("accept_err", {30'b0, err}, 32'd0);
    checkOutput("accept_csib", {31'b0, icap_csib}, 32'd1);

    if (w >= TMO)        end_k = TMO;
    else if (drop_d >= 0) end_k = 2 + w + drop_d;
    else                  end_k = 2 + w + n;

    for (int k = 1; k <= end_k; k++) begin
      icap_avail = (k > w) && !(drop_d >= 0 && k == 2 + w + drop_d);
      reboot     = use_reboot ? (pin_e < 5) : (toggle_busy && k <= 3);
      step();
      pin_e++;
      s = k - 2 - w;
      exp_csib = 1'b1; exp_busy = 1'b1; exp_done = 1'b0; exp_ready = 1'b0; exp_err = 2'b00;
      if (w >= TMO) begin
        if (k == TMO) begin
          exp_busy = 1'b0; exp_ready = 1'b1; exp_err = 2'b01;
        end
      end else if (s >= 0) begin
        if (drop_d >= 0 && s == drop_d) begin
          exp_busy = 1'b0; exp_ready = 1'b1; exp_err = 2'b10;
        end else if (s == n) begin
          exp_busy = 1'b0; exp_ready = 1'b1; exp_done = 1'b1;
        end else begin
          exp_csib = 1'b0;
        end
      end
      checkOutput("seq_csib", {31'b0, icap_csib}, {31'b0, exp_csib});
      checkOutput("seq_busy", {31'b0, busy}, {31'b0, exp_busy});
      checkOutput("seq_done", {31'b0, done}, {31'b0, exp_done});
      checkOutput("seq_ready", {31'b0, req_ready}, {31'b0, exp_ready});
      checkOutput("seq_err", {30'b0, err}, {30'b0, exp_err});
      checkOutput("seq_rdwrb", {31'b0, icap_rdwrb}, 32'd0);
      if (!exp_csib) checkOutput("seq_word", unswap(icap_i), words[s]);
      else           checkOutput("seq_idle_word", icap_i, 32'hFFFF_FFFF);
    end
    last_err   = exp_err;
    reboot     = 1'b0;
    icap_avail = 1'b1;
  endtask

  task automatic idleGap(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step();
      checkIdle(last_err);
    end
  endtask

  task automatic resetMidSequence(input logic [31:0] addr);
    req_valid  = 1'b1;
    req_addr   = addr;
    req_wbstar = 1'b1;
    icap_avail = 1'b1;
    step();
    req_valid = 1'b0;
    for (int k = 1; k <= 6; k++) step();
    checkOutput("rst_pre_csib", {31'b0, icap_csib}, 32'd0);
    checkOutput("rst_pre_word4", unswap(icap_i), addr);
    rst_n = 1'b0;
    step();
    checkOutput("rst_csib", {31'b0, icap_csib}, 32'd1);
    checkOutput("rst_icap_i", icap_i, 32'hFFFF_FFFF);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("rst_done", {31'b0, done}, 32'd0);
    rst_n = 1'b1;
    step();
    last_err = 2'b00;
    checkIdle(2'b00);
    idleGap(10);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  n, w, drop_d, gap;
    bit  use_reboot, wb, tog;

    tests_run    = 0;
    tests_failed = 0;
    last_err     = 2'b00;
    rst_n        = 1'b0;
    reboot       = 1'b0;
    req_valid    = 1'b0;
    req_addr     = 32'h0;
    req_wbstar   = 1'b0;
    icap_avail   = 1'b1;

    for (int i = 0; i < 3; i++) step();
    checkOutput("reset_csib", {31'b0, icap_csib}, 32'd1);
    checkOutput("reset_icap_i", icap_i, 32'hFFFF_FFFF);
    checkOutput("reset_rdwrb", {31'b0, icap_rdwrb}, 32'd0);
    checkOutput("reset_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_done", {31'b0, done}, 32'd0);
    checkOutput("reset_err", {30'b0, err}, 32'd0);
    rst_n = 1'b1;
    step();
    checkIdle(2'b00);

    applyStimulus(1'b1, 1'b0, 32'h0100_0000, 1'b1, 0, -1, 1'b0);
    idleGap(2);
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 0, -1, 1'b0);
    idleGap(2);
    applyStimulus(1'b1, 1'b0, $urandom, 1'b1, TMO, -1, 1'b0);
    idleGap(2);
    applyStimulus(1'b1, 1'b0, $urandom, 1'b0, 0, 3, 1'b0);
    idleGap(2);
    applyStimulus(1'b1, 1'b0, $urandom, 1'b1, 1, -1, 1'b0);
    idleGap(1);
    applyStimulus(1'b1, 1'b1, 32'hCAFE_0000, 1'b1, 0, -1, 1'b0);
    idleGap(8);
    applyStimulus(1'b1, 1'b0, $urandom, 1'b0, 1, -1, 1'b1);
    idleGap(8);
    resetMidSequence(32'h0ABC_0000);

    for (int it = 0; it < 40; it++) begin
      use_reboot = ($urandom_range(0, 3) == 0);
      wb         = $urandom_range(0, 1);
      n          = use_reboot ? ((REBOOT_WB != 0) ? 8 : 6) : (wb ? 8 : 6);
      w          = ($urandom_range(0, 7) == 0) ? TMO + $urandom_range(0, 2) : $urandom_range(0, 4);
      drop_d     = (w < TMO && $urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
      tog        = !use_reboot && w < TMO && drop_d < 0 && ($urandom_range(0, 1) == 1);
      applyStimulus(!use_reboot, use_reboot, $urandom, wb, w, drop_d, tog);
      gap = $urandom_range(0, 3);
      idleGap(gap);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
